// File: rtl/fcfs_request_queue.sv
// First-come-first-served request queue: requesters are enqueued round-robin,
// at most one per cycle, and served strictly in arrival order from the head entry.
module fcfs_request_queue #(
    parameter int N      = 4,
    parameter int DEPTH  = 4,
    parameter int CANCEL = 1,
    localparam int IW    = ($clog2(N) > 1) ? $clog2(N) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          deq_ready,
    output logic          deq_valid,
    output logic [IW-1:0] deq_idx,
    output logic [N-1:0]  deq_onehot,
    output logic [CW-1:0] count,
    output logic          is_full,
    output logic          is_empty
);

    logic [IW-1:0] entries_q [DEPTH];
    logic [IW-1:0] entries_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  queued_q, queued_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          deq_fire;
    logic          space_ok;
    logic [N-1:0]  eligible;
    logic          enq_fire;
    logic [IW-1:0] enq_idx;

    // Outputs depend on registered state only, never on req or deq_ready.
    assign deq_valid  = (count_q != '0);
    assign deq_idx    = deq_valid ? entries_q[0] : '0;
    assign deq_onehot = deq_valid ? (N'(1) << entries_q[0]) : '0;
    assign count      = count_q;
    assign is_full    = (count_q == CW'(DEPTH));
    assign is_empty   = (count_q == '0);

    assign deq_fire = deq_valid && deq_ready;
    assign space_ok = (count_q < CW'(DEPTH)) || deq_fire;
    // queued_q still marks the head being dequeued, so it cannot re-enter this edge.
    assign eligible = req & ~queued_q;

    // Round-robin pick: first eligible index at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        enq_fire = 1'b0;
        enq_idx  = '0;
        for (int k = 0; k < N; k++) begin
            int pos;
            pos = (int'(rr_ptr_q) + k) % N;
            if (space_ok && !enq_fire && eligible[pos]) begin
                enq_fire = 1'b1;
                enq_idx  = IW'(pos);
            end
        end
    end

    // Remove the handshaken head and any cancelled entries, compact survivors,
    // then append the new entry at the first free slot.
    always_comb begin : next_state
        int wp;
        wp       = 0;
        queued_d = queued_q;
        for (int p = 0; p < DEPTH; p++) begin
            entries_d[p] = '0;
        end
        for (int p = 0; p < DEPTH; p++) begin
            if (p < int'(count_q)) begin
                if ((p == 0 && deq_fire) || (CANCEL != 0 && !req[entries_q[p]])) begin
                    queued_d[entries_q[p]] = 1'b0;
                end else begin
                    entries_d[wp] = entries_q[p];
                    wp++;
                end
            end
        end
        if (enq_fire) begin
            entries_d[wp]     = enq_idx;
            queued_d[enq_idx] = 1'b1;
            wp++;
        end
        count_d  = CW'(wp);
        rr_ptr_d = enq_fire ? IW'((int'(enq_idx) + 1) % N) : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the entry array is reset too, so no stale index survives a mid-run reset.
            for (int p = 0; p < DEPTH; p++) begin
                entries_q[p] <= '0;
            end
            count_q  <= '0;
            queued_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together.
            for (int p = 0; p < DEPTH; p++) begin
                entries_q[p] <= entries_d[p];
            end
            count_q  <= count_d;
            queued_q <= queued_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_fcfs_request_queue.sv
// Bench for fcfs_request_queue: three configurations driven in parallel and
// compared every cycle against a queue-based reference model.
module tb_fcfs_request_queue;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic          deq_ready;

    logic          dv  [3];
    logic [1:0]    di  [3];
    logic [NR-1:0] oh  [3];
    logic          fu  [3];
    logic          em  [3];
    logic [2:0]    cnt0;
    logic [1:0]    cnt1;
    logic [2:0]    cnt2;

    int dep [3] = '{4, 2, 4};
    int can [3] = '{1, 1, 0};
    int mq  [3][$];
    int mrr [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fcfs_request_queue #(.N(NR), .DEPTH(4), .CANCEL(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .deq_ready(deq_ready),
        .deq_valid(dv[0]), .deq_idx(di[0]), .deq_onehot(oh[0]),
        .count(cnt0), .is_full(fu[0]), .is_empty(em[0])
    );

    fcfs_request_queue #(.N(NR), .DEPTH(2), .CANCEL(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req(req), .deq_ready(deq_ready),
        .deq_valid(dv[1]), .deq_idx(di[1]), .deq_onehot(oh[1]),
        .count(cnt1), .is_full(fu[1]), .is_empty(em[1])
    );

    fcfs_request_queue #(.N(NR), .DEPTH(4), .CANCEL(0)) u_nc (
        .clk(clk), .rst_n(rst_n), .req(req), .deq_ready(deq_ready),
        .deq_valid(dv[2]), .deq_idx(di[2]), .deq_onehot(oh[2]),
        .count(cnt2), .is_full(fu[2]), .is_empty(em[2])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cnt_of(input int m);
        case (m)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int entry_of(input int m, input int p);
        case (m)
            0:       return int'(u_dut.entries_q[p]);
            1:       return int'(u_d2.entries_q[p]);
            default: return int'(u_nc.entries_q[p]);
        endcase
    endfunction

    // Reference: list of queued requesters in arrival order, head first.
    task automatic model_step(input int m);
        int  old[$];
        int  nq[$];
        bit  deq;
        bit  inq;
        int  sel;
        old = mq[m];
        deq = (old.size() > 0) && deq_ready;
        foreach (old[p]) begin
            if (p == 0 && deq) continue;
            if (can[m] != 0 && !req[old[p]]) continue;
            nq.push_back(old[p]);
        end
        if (old.size() < dep[m] || deq) begin
            sel = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i   = (mrr[m] + k) % NR;
                inq = 1'b0;
                foreach (old[j]) if (old[j] == i) inq = 1'b1;
                if (sel < 0 && req[i] && !inq) sel = i;
            end
            if (sel >= 0) begin
                nq.push_back(sel);
                mrr[m] = (sel + 1) % NR;
            end
        end
        mq[m] = nq;
    endtask

    task automatic compare_all(input string nm);
        for (int m = 0; m < 3; m++) begin
            int s;
            string t;
            s = mq[m].size();
            t = $sformatf("%s/u%0d", nm, m);
            check({t, "/count"},  cnt_of(m), s);
            check({t, "/valid"},  int'(dv[m]), (s > 0) ? 1 : 0);
            check({t, "/idx"},    int'(di[m]), (s > 0) ? mq[m][0] : 0);
            check({t, "/onehot"}, int'(oh[m]), (s > 0) ? (1 << mq[m][0]) : 0);
            check({t, "/full"},   int'(fu[m]), (s == dep[m]) ? 1 : 0);
            check({t, "/empty"},  int'(em[m]), (s == 0) ? 1 : 0);
            for (int p = 0; p < s; p++) begin
                check($sformatf("%s/entry%0d", t, p), entry_of(m, p), mq[m][p]);
            end
        end
    endtask

    // Called just after a falling edge with the inputs for the coming rising edge set.
    task automatic tick();
        for (int m = 0; m < 3; m++) model_step(m);
        @(posedge clk);
        @(negedge clk);
        compare_all("cyc");
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 3; m++) begin
            mq[m].delete();
            mrr[m] = 0;
        end
        compare_all("rst");
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        deq_ready = 1'b0;
        for (int m = 0; m < 3; m++) mrr[m] = 0;
        #3;
        check("por_count",  int'(cnt0),  0);
        check("por_empty",  int'(em[0]), 1);
        check("por_full",   int'(fu[0]), 0);
        check("por_valid",  int'(dv[0]), 0);
        check("por_idx",    int'(di[0]), 0);
        check("por_onehot", int'(oh[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ordering: two requesters, consumer stalled.
        req = 4'b1010;
        tick();
        check("ord1_idx",   int'(di[0]), 1);
        check("ord1_count", int'(cnt0),  1);
        tick();
        check("ord2_count", int'(cnt0), 2);
        check("ord2_e0",    entry_of(0, 0), 1);
        check("ord2_e1",    entry_of(0, 1), 3);
        repeat (3) begin
            tick();
            check("ord_hold", int'(cnt0), 2);
        end

        // Cancel: build [2,0,3], then drop req[0].
        reset_pulse();
        req = 4'b0100; tick();
        req = 4'b0101; tick();
        req = 4'b1101; tick();
        check("can_pre_count", int'(cnt0), 3);
        req = 4'b1100; tick();
        check("can_count", int'(cnt0), 2);
        check("can_e0",    entry_of(0, 0), 2);
        check("can_e1",    entry_of(0, 1), 3);
        check("nc_count",  int'(cnt2), 3);
        check("nc_e0",     entry_of(2, 0), 2);
        check("nc_e1",     entry_of(2, 1), 0);
        check("nc_e2",     entry_of(2, 2), 3);

        // Reset with three entries held, then restart from rr_ptr 0.
        req = 4'b1000;
        reset_pulse();
        check("rst3_count", int'(cnt2),  0);
        check("rst3_empty", int'(em[2]), 1);
        check("rst3_valid", int'(dv[2]), 0);
        tick();
        check("rst3_first_idx",   int'(di[0]), 3);
        check("rst3_first_valid", int'(dv[0]), 1);

        // Head handshaken and cancelled on the same edge: one removal.
        req = 4'b1010; tick();
        check("sec_pre_count", int'(cnt0), 2);
        req = 4'b0010; deq_ready = 1'b1; tick();
        check("sec_count", int'(cnt0),  1);
        check("sec_idx",   int'(di[0]), 1);
        req = 4'b0000; deq_ready = 1'b0; tick();

        // Full queue with DEPTH=2, then dequeue and enqueue on one edge.
        reset_pulse();
        req = 4'b1111;
        tick(); tick(); tick();
        check("full_count", int'(cnt1),  2);
        check("full_flag",  int'(fu[1]), 1);
        check("full_e0",    entry_of(1, 0), 0);
        check("full_e1",    entry_of(1, 1), 1);
        deq_ready = 1'b1; tick();
        deq_ready = 1'b0;
        check("swap_count", int'(cnt1),  2);
        check("swap_flag",  int'(fu[1]), 1);
        check("swap_e0",    entry_of(1, 0), 1);
        check("swap_e1",    entry_of(1, 1), 2);

        // Re-arm: single requester with a constantly ready consumer.
        reset_pulse();
        req = 4'b0001; deq_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("rearm_valid%0d", k), int'(dv[0]), k % 2);
            check($sformatf("rearm_idx%0d", k),   int'(di[0]), 0);
        end

        // Randomized traffic with slowly changing request levels.
        req = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) == 0) req = req ^ 4'(1 << $urandom_range(0, 3));
            deq_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) reset_pulse();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
